// File: rtl/if_stage_buf.sv
// if_stage_buf: multi-outstanding instruction fetch stage with in-order fetch buffer.
// Define IF_ADEF_EN to turn misaligned fetch PCs into adef-tagged buffer entries.
module if_stage_buf #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_to_id_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adef
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          pend_vld;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] dis_cnt;
  logic [CW-1:0] occ;
  logic [31:0]   pcq [BUF_DEPTH];
  logic [AW-1:0] pcq_wp;
  logic [AW-1:0] pcq_rp;
  logic [31:0]   bq_pc [BUF_DEPTH];
  logic [31:0]   bq_inst [BUF_DEPTH];
  logic [AW-1:0] bq_wp;
  logic [AW-1:0] bq_rp;
  logic [CW:0]   used;
  logic          stall;
  logic          adef_push;
  logic          acc;
  logic          rsp;
  logic          drop;
  logic          push;
  logic          pop;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

`ifdef IF_ADEF_EN
  logic adef_done;
  logic bq_adef [BUF_DEPTH];

  assign stall          = |fetch_pc[1:0];
  assign adef_push      = stall & ~adef_done & ~br_taken
                        & (out_cnt == dis_cnt)
                        & (occ < CW'(BUF_DEPTH));
  assign inst_sram_addr = fetch_pc;
  assign if_adef        = if_to_id_valid & bq_adef[bq_rp];

  // one adef entry per misaligned target; cleared by the next redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      adef_done <= 1'b0;
    end else if (br_taken) begin
      adef_done <= 1'b0;
    end else if (adef_push) begin
      adef_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      bq_adef[bq_wp] <= adef_push;
    end
  end
`else
  assign stall          = 1'b0;
  assign adef_push      = 1'b0;
  assign inst_sram_addr = {fetch_pc[31:2], 2'b00};
  assign if_adef        = 1'b0;
`endif

  assign used = {1'b0, out_cnt} + {1'b0, occ} - (CW+1)'(pop);
  assign inst_sram_req = ~reset & ~stall
                       & (used < (CW+1)'(BUF_DEPTH));

  assign acc  = inst_sram_req & inst_sram_addr_ok;
  assign rsp  = inst_sram_data_ok & (out_cnt != '0);
  assign drop = br_taken | (dis_cnt != '0);
  assign push = (rsp & ~drop) | adef_push;
  assign pop  = if_to_id_valid & id_allowin & ~br_taken;

  assign push_pc   = adef_push ? fetch_pc : pcq[pcq_rp];
  assign push_inst = adef_push ? 32'h0 : inst_sram_rdata;

  assign if_to_id_valid = (occ != '0);
  assign if_pc   = if_to_id_valid ? bq_pc[bq_rp]   : 32'h0;
  assign if_inst = if_to_id_valid ? bq_inst[bq_rp] : 32'h0;

  // an unaccepted request must keep its address, so the target waits as pending
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= 32'h0;
      pend_vld <= 1'b0;
    end else if (br_taken) begin
      if (inst_sram_req & ~inst_sram_addr_ok) begin
        pend_vld <= 1'b1;
        pend_pc  <= br_target;
      end else begin
        pend_vld <= 1'b0;
        fetch_pc <= br_target;
      end
    end else if (acc) begin
      fetch_pc <= pend_vld ? pend_pc : fetch_pc + 32'd4;
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt <= '0;
      dis_cnt <= '0;
      occ     <= '0;
      pcq_wp  <= '0;
      pcq_rp  <= '0;
      bq_wp   <= '0;
      bq_rp   <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(acc) - CW'(rsp);
      if (acc) pcq_wp <= pcq_wp + 1'b1;
      if (rsp) pcq_rp <= pcq_rp + 1'b1;
      if (br_taken) begin
        dis_cnt <= out_cnt + CW'(acc) - CW'(rsp);
        occ     <= '0;
        bq_wp   <= '0;
        bq_rp   <= '0;
      end else begin
        dis_cnt <= dis_cnt + CW'(acc & pend_vld)
                 - CW'(rsp & (dis_cnt != '0));
        occ     <= occ + CW'(push) - CW'(pop);
        if (push) bq_wp <= bq_wp + 1'b1;
        if (pop)  bq_rp <= bq_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      pcq[pcq_wp] <= inst_sram_addr;
    end
    if (push) begin
      bq_pc[bq_wp]   <= push_pc;
      bq_inst[bq_wp] <= push_inst;
    end
  end

endmodule

// File: tb/tb_if_stage_buf.sv
// tb_if_stage_buf: directed bench for if_stage_buf with a queued SRAM model.
// Define IF_ADEF_EN to also exercise the misaligned-target entry.
module tb_if_stage_buf;
  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adef;

  logic aok = 1'b1;
  int   lat = 1;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   n_run = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] a;
    int          rdy;
  } mreq_t;
  mreq_t mq[$];

  assign inst_sram_addr_ok = aok;

  if_stage_buf dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .id_allowin(id_allowin), .br_taken(br_taken), .br_target(br_target),
    .if_to_id_valid(if_to_id_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_adef(if_adef)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h5a5a0f0f;
  endfunction

  // memory: accepts on req&addr_ok, answers in order after lat cycles
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
    end else begin
      if (inst_sram_data_ok) void'(mq.pop_front());
      if (inst_sram_req && inst_sram_addr_ok) begin
        mq.push_back('{a: inst_sram_addr, rdy: cyc + lat});
        acc_cnt++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mq.size() > 0 && mq[0].rdy <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = ins(mq[0].a);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic a, input logic ida, input int l);
    reset = 1'b1;
    br_taken = 1'b0;
    aok = a;
    id_allowin = ida;
    lat = l;
    repeat (3) tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_run++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", inst_sram_req); end
    n_run++; if (if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_to_id_valid); end
    n_run++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    n_run++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", if_inst); end
    n_run++; if (if_adef !== 1'b0) begin n_fail++; $display("FAIL rst_adef: got %b want 0", if_adef); end
    n_run++; if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb} !== 7'b0100000) begin
      n_fail++; $display("FAIL rst_const: got %b want 0100000", {inst_sram_wr, inst_sram_size, inst_sram_wstrb}); end
    n_run++; if (inst_sram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", inst_sram_wdata); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset(1'b1, 1'b1, 1);
    n_run++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin
      n_fail++; $display("FAIL c0_req: got %b/%h want 1/%h", inst_sram_req, inst_sram_addr, RPC); end
    tick();
    n_run++; if (if_to_id_valid !== 1'b0 || inst_sram_addr !== RPC + 32'd4) begin
      n_fail++; $display("FAIL c1: got v=%b a=%h want v=0 a=%h", if_to_id_valid, inst_sram_addr, RPC + 32'd4); end
    tick();
    for (int k = 0; k < 6; k++) begin
      exp = RPC + 32'(4 * k);
      n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== exp) begin
        n_fail++; $display("FAIL stream_pc%0d: got v=%b pc=%h want 1/%h", k, if_to_id_valid, if_pc, exp); end
      n_run++; if (if_inst !== ins(exp) || if_adef !== 1'b0) begin
        n_fail++; $display("FAIL stream_inst%0d: got %h/%b want %h/0", k, if_inst, if_adef, ins(exp)); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int a0;
    logic [31:0] exp;
    do_reset(1'b1, 1'b0, 1);
    a0 = acc_cnt;
    repeat (10) tick();
    n_run++; if (acc_cnt - a0 != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", acc_cnt - a0); end
    n_run++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b want 0", inst_sram_req); end
    n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== RPC) begin
      n_fail++; $display("FAIL bp_head: got %b/%h want 1/%h", if_to_id_valid, if_pc, RPC); end
    id_allowin = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp = RPC + 32'(4 * k);
      n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== exp) begin
        n_fail++; $display("FAIL drain%0d: got %b/%h want 1/%h", k, if_to_id_valid, if_pc, exp); end
      tick();
    end
  endtask

  task automatic test_discard();
    int w;
    do_reset(1'b1, 1'b1, 5);
    repeat (2) tick();
    br_taken = 1'b1;
    br_target = 32'h1c000100;
    tick();
    br_taken = 1'b0;
    #1;
    n_run++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
      n_fail++; $display("FAIL disc_addr: got %b/%h want 1/1c000100", inst_sram_req, inst_sram_addr); end
    w = 0;
    while (!if_to_id_valid && w < 30) begin tick(); w++; end
    n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== 32'h1c000100 || if_inst !== ins(32'h1c000100)) begin
      n_fail++; $display("FAIL disc_first: got %b/%h/%h want 1/1c000100/%h", if_to_id_valid, if_pc, if_inst, ins(32'h1c000100)); end
    lat = 1;
  endtask

  task automatic test_pending();
    int w;
    do_reset(1'b0, 1'b1, 1);
    tick();
    br_taken = 1'b1;
    br_target = 32'h1c000200;
    #1;
    n_run++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin
      n_fail++; $display("FAIL pend_c1: got %b/%h want 1/%h", inst_sram_req, inst_sram_addr, RPC); end
    tick();
    br_taken = 1'b0;
    #1;
    n_run++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== RPC) begin
      n_fail++; $display("FAIL pend_c2: got %b/%h want 1/%h", inst_sram_req, inst_sram_addr, RPC); end
    tick();
    aok = 1'b1;
    #1;
    n_run++; if (inst_sram_addr !== RPC) begin n_fail++; $display("FAIL pend_c3: got %h want %h", inst_sram_addr, RPC); end
    tick();
    n_run++; if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin
      n_fail++; $display("FAIL pend_tgt: got %b/%h want 1/1c000200", inst_sram_req, inst_sram_addr); end
    w = 0;
    while (!if_to_id_valid && w < 30) begin tick(); w++; end
    n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== 32'h1c000200) begin
      n_fail++; $display("FAIL pend_first: got %b/%h want 1/1c000200", if_to_id_valid, if_pc); end
  endtask

  task automatic test_coincident();
    int w;
    do_reset(1'b1, 1'b1, 1);
    repeat (3) tick();
    n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== RPC + 32'd4) begin
      n_fail++; $display("FAIL coin_pre: got %b/%h want 1/%h", if_to_id_valid, if_pc, RPC + 32'd4); end
    br_taken = 1'b1;
    br_target = 32'h1c000300;
    tick();
    br_taken = 1'b0;
    #1;
    n_run++; if (if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL coin_flush: got %b want 0", if_to_id_valid); end
    w = 0;
    while (!if_to_id_valid && w < 30) begin tick(); w++; end
    n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== 32'h1c000300) begin
      n_fail++; $display("FAIL coin_first: got %b/%h want 1/1c000300", if_to_id_valid, if_pc); end
  endtask

`ifdef IF_ADEF_EN
  task automatic test_adef();
    int w;
    do_reset(1'b1, 1'b1, 1);
    repeat (3) tick();
    br_taken = 1'b1;
    br_target = 32'h1c000102;
    tick();
    br_taken = 1'b0;
    #1;
    n_run++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL adef_req: got %b want 0", inst_sram_req); end
    w = 0;
    while (!if_to_id_valid && w < 30) begin tick(); w++; end
    n_run++; if (if_to_id_valid !== 1'b1 || if_pc !== 32'h1c000102 || if_adef !== 1'b1 || if_inst !== 32'h0) begin
      n_fail++; $display("FAIL adef_entry: got %b/%h/%b/%h want 1/1c000102/1/0", if_to_id_valid, if_pc, if_adef, if_inst); end
    repeat (4) tick();
    n_run++; if (if_to_id_valid !== 1'b0 || inst_sram_req !== 1'b0) begin
      n_fail++; $display("FAIL adef_stall: got v=%b req=%b want 0/0", if_to_id_valid, inst_sram_req); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_discard();
    test_pending();
    test_coincident();
`ifdef IF_ADEF_EN
    test_adef();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
